// File: rtl/jk_cnt_pkg.sv
// Shared JK excitation encodings and the helper that picks the J/K pair
// needed to move a single flip-flop from its current value to a wanted one.
package jk_cnt_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // Returns {j,k}; unchanged bits always get HOLD so idle stages see J=K=0.
   function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
      logic [1:0] jk;
      if (cur == nxt)
         jk = JK_HOLD;
      else if (nxt)
         jk = JK_SET;
      else
         jk = JK_CLR;
      return jk;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop stage with asynchronous active-low clear.
module jk_cell
   import jk_cnt_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            JK_HOLD: q <= q;
            JK_CLR:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            JK_TGL:  q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter built from JK stages, with parallel load and cascade tc.
// Define JK_CNT_SAT_EN to saturate at the terminal values instead of wrapping.
module jk_updown_counter
   import jk_cnt_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   // One bit wider so MODULUS == 2**WIDTH is representable in the clamp compare.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             wrap_nxt;

   always_comb begin
      tc = en & ((up & (q == MAX_VAL)) | (~up & (q == '0)));
   end

   always_comb begin
      nxt      = q;
      wrap_nxt = 1'b0;
      if (load) begin
         nxt = ({1'b0, d} >= MOD_EXT) ? MAX_VAL : d;
      end else if (en) begin
`ifdef JK_CNT_SAT_EN
         if (!tc)
            nxt = up ? q + ONE : q - ONE;
`else
         if (tc)
            nxt = up ? '0 : MAX_VAL;
         else
            nxt = up ? q + ONE : q - ONE;
         wrap_nxt = tc;
`endif
      end
   end

   always_comb begin
      j = '0;
      k = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {j[i], k[i]} = jk_excite(q[i], nxt[i]);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j[i]),
         .k     (k[i]),
         .q     (q[i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wrap <= 1'b0;
      else
         wrap <= wrap_nxt;
   end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench for jk_updown_counter (WIDTH=4, MODULUS=10), wrap or saturate build.
module tb_jk_updown_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;

   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic             en    = 1'b0;
   logic             up    = 1'b1;
   logic             load  = 1'b0;
   logic [WIDTH-1:0] d     = '0;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

   jk_updown_counter #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .up    (up),
      .load  (load),
      .d     (d),
      .q     (q),
      .tc    (tc),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             tc;
      logic             wrap;
      string            name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   event async_ev;
   bit   async_flag = 1'b0;

   task automatic push(input logic [WIDTH-1:0] eq, input logic etc, input logic ew,
                       input string nm);
      exp_t e;
      e.q    = eq;
      e.tc   = etc;
      e.wrap = ew;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Drive one cycle of inputs and queue the state expected just after the next edge.
   task automatic step(input logic rs, input logic ld, input logic e_, input logic u,
                       input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] eq,
                       input logic etc, input logic ew, input string nm);
      @(negedge clk);
      reset = rs;
      load  = ld;
      en    = e_;
      up    = u;
      d     = dv;
      push(eq, etc, ew, nm);
   endtask

   task automatic async_check(input logic [WIDTH-1:0] eq, input logic etc,
                              input logic ew, input string nm);
      push(eq, etc, ew, nm);
      async_flag = 1'b1;
      ->async_ev;
   endtask

   // Monitor: samples 1ns after each rising edge, or immediately on an async request.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or async_ev);
         if (async_flag)
            async_flag = 1'b0;
         else
            #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.q || tc !== e.tc || wrap !== e.wrap) begin
               errors++;
               $display("FAIL %s: got q=%0d tc=%0b wrap=%0b, expected q=%0d tc=%0b wrap=%0b",
                        e.name, q, tc, wrap, e.q, e.tc, e.wrap);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held from time 0: outputs forced without any clock edge.
      #2;
      async_check(4'd0, 1'b0, 1'b0, "reset_state");
      #1;
      en = 1'b1;
      up = 1'b0;
      #1;
      async_check(4'd0, 1'b1, 1'b0, "reset_tc_down");

      step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, "release_hold");

      for (int i = 1; i <= 9; i++)
         step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'(i), (i == 9), 1'b0, "count_up");
`ifdef JK_CNT_SAT_EN
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b0, "sat_up_hold");
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 1'b0, "sat_up_hold2");
`else
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "up_wrap");
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, "wrap_clear");
`endif

      // Mid-count asynchronous reset at q=6.
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 4'd6, 1'b0, 1'b0, "load6");
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      async_check(4'd0, 1'b0, 1'b0, "async_rst");
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, "rst_first_count");

      // Down count through zero.
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "down_to_zero");
`ifdef JK_CNT_SAT_EN
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "sat_down_hold");
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, "sat_down_hold2");
`else
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1, "down_wrap");
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0, "down_after");
`endif

      // Load priority, clamping, and no wrap after loading a terminal value.
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  4'd5, 1'b0, 1'b0, "load_priority");
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 4'd9, 1'b1, 1'b0, "load_clamp12");
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  4'd9, 1'b1, 1'b0, "load_term_nowrap");
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 4'd9, 1'b0, 1'b0, "load_clamp15");

      // Hold with en=0, then direction flips every cycle.
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, "load3");
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 1'b0, ((i % 2) == 1), 4'd0, 4'd3, 1'b0, 1'b0, "hold");
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, "toggle_up1");
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, "toggle_dn1");
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, "toggle_up2");
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, "toggle_dn2");

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MODULUS, default 16: count range is 0..MODULUS-1; legal range is 2 <= MODULUS <= 2**WIDTH.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port en, input, 1: count enable.
REQ-006 Port up, input, 1: direction select; 1 = increment, 0 = decrement.
REQ-007 Port load, input, 1: synchronous parallel-load strobe.
REQ-008 Port d, input, WIDTH: parallel-load value.
REQ-009 Port q, output, WIDTH: registered count value.
REQ-010 Port tc, output, 1: combinational terminal count, for cascading.
REQ-011 Port wrap, output, 1: registered one-cycle pulse on each wrap event.

Function
REQ-012 Each bit of q SHALL be held in a JK stage, with next state produced only via J/K excitation: hold=00, clear=01, set=10, toggle=11.
REQ-013 Priority each edge SHALL be: load > en > hold.
REQ-014 With load=1, q SHALL take d next edge, irrespective of en and up.
REQ-015 With load=1 and d >= MODULUS, q SHALL take MODULUS-1.
REQ-016 With load=0, en=1, up=1: q SHALL go q+1, and from MODULUS-1 SHALL wrap to 0.
REQ-017 With load=0, en=1, up=0: q SHALL go q-1, and from 0 SHALL wrap to MODULUS-1.
REQ-018 With load=0, en=0: q SHALL hold, with all stages receiving J=K=0.
REQ-019 tc SHALL be 1 when en=1 and either (up=1 and q==MODULUS-1) or (up=0 and q==0); otherwise tc SHALL be 0.
REQ-020 tc SHALL be 1 in the same cycle as the terminal value, with zero latency.
REQ-021 wrap SHALL be 1 for exactly the cycle after an edge where tc=1 and load=0.
REQ-022 wrap SHALL be 0 after a load, even when a terminal value is loaded.
REQ-023 Latency from en/load sampling to q update SHALL be one clock.
REQ-024 Changing up while en=1 SHALL take effect on the next edge without glitching q.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clk, force q=0 and wrap=0.
REQ-026 tc SHALL follow REQ-019 from the reset value of q.
REQ-027 Reset asserted mid-count SHALL abort counting, and the first enabled edge after release SHALL count from 0.
REQ-028 Release of reset SHALL NOT itself change q.

Configuration
REQ-029 Macro JK_CNT_SAT_EN SHALL select saturation behaviour.
REQ-030 With JK_CNT_SAT_EN defined, at a terminal value with tc=1, q SHALL hold (up stops at MODULUS-1, down stops at 0), tc SHALL still assert, and wrap SHALL stay 0.
REQ-031 Without JK_CNT_SAT_EN, the wrap behaviour of REQ-016/017/021 SHALL apply.

Structure
REQ-032 Shared package jk_cnt_pkg SHALL hold the four 2-bit JK excitation constants (JK_HOLD, JK_CLR, JK_SET, JK_TGL).
REQ-033 jk_cnt_pkg SHALL hold a function returning the JK pair for a (current, next) bit transition.
REQ-034 Sub-module jk_cell SHALL implement one JK stage (clk, reset, j, k -> q).
REQ-035 jk_updown_counter SHALL instantiate WIDTH copies of jk_cell plus next-state/excitation logic and the wrap register.

Verification
REQ-036 Reset: WIDTH=4, MODULUS=10; pulse reset low mid-cycle at q=6 -> q=0 before next clk edge, wrap=0; hold en=1, up=1 -> q=1 after first edge.
REQ-037 Up wrap: MODULUS=10, count from 0 with en=1, up=1 -> q reaches 9, tc=1 at q=9 -> next edge q=0, wrap=1 for one cycle.
REQ-038 Down wrap: q=0, up=0, en=1 -> tc=1, next edge q=9, wrap=1 -> then q=8, wrap=0.
REQ-039 Load priority and clamp: load=1, d=5, en=1 -> q=5 with no count; load=1, d=12 -> q=9, wrap=0.
REQ-040 Hold: en=0 for 5 cycles at q=3 -> q stays 3, tc=0; toggle up each cycle with en=1 -> q follows 4,3,4,3.
REQ-041 Saturation (JK_CNT_SAT_EN defined): q=9, up=1, en=1 -> q stays 9, tc=1, wrap=0; q=0, up=0 -> q stays 0.
